// File: rtl/mem_access.sv
// mem_access: load/store unit turning one load/store into a handshaked word-bus transaction.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start/i_memRead/i_memWrite/i_size/
// i_unsigned/i_addr/i_wdata describe the instruction; o_bus_* and i_bus_ack/i_bus_rdata form
// the word bus; o_stall holds the core; o_rdata/o_rdata_valid/o_misalign/o_bus_err report results.
module mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misalign,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(MAX_WAIT + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [29:0] addr_q;
  logic [3:0] be_q, be;
  logic [31:0] wdata_q, wd, ext, rdata_q;
  logic [1:0] size_q, lane_q;
  logic we_q, uns_q, v_q, mis_q, err_q;
  logic access, misalign, timeout;
  logic [7:0] b;
  logic [15:0] h;
  assign access = i_start & (i_memRead | i_memWrite);
  assign misalign = (i_size == 2'b01 & i_addr[0]) | (i_size[1] & |i_addr[1:0]);
  assign timeout = cnt == CW'(MAX_WAIT);
  assign be = i_size[1] ? 4'b1111 : i_size[0] ? 4'b0011 << {i_addr[1], 1'b0} : 4'b0001 << i_addr[1:0];
  assign wd = i_size[1] ? i_wdata : i_size[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
  assign b = i_bus_rdata[{lane_q, 3'b000} +: 8];
  assign h = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
  assign ext = size_q[1] ? i_bus_rdata : size_q[0] ? {{16{~uns_q & h[15]}}, h} : {{24{~uns_q & b[7]}}, b};
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (access ? (misalign ? DONE : REQ) : IDLE)
            : state == REQ ? ((i_bus_ack | timeout) ? DONE : REQ)
            : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      lane_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      v_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else if (state == IDLE && access) begin
      mis_q <= misalign;
      v_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      if (!misalign) begin
        we_q <= i_memWrite;
        addr_q <= i_addr[31:2];
        be_q <= be;
        wdata_q <= wd;
        size_q <= i_size;
        uns_q <= i_unsigned;
        lane_q <= i_addr[1:0];
      end
    end else if (state == REQ) begin
      if (i_bus_ack) begin
        v_q <= ~we_q;
        rdata_q <= we_q ? '0 : ext;
      end else if (timeout) err_q <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  assign o_bus_req = state == REQ;
  assign o_bus_we = we_q;
  assign o_bus_addr = {addr_q, 2'b00};
  assign o_bus_be = be_q;
  assign o_bus_wdata = wdata_q;
  assign o_stall = (state == IDLE & access) | state == REQ;
  assign o_rdata = rdata_q;
  assign o_rdata_valid = state == DONE & v_q;
  assign o_misalign = state == DONE & mis_q;
  assign o_bus_err = state == DONE & err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
module tb_mem_access;
  logic clk = 0, rst_n = 0, start = 0, mem_read = 0, mem_write = 0, uns = 0, ack = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, rdata_in = 0;
  logic req, we, stall, valid, mis, err;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0] be;
  int total = 0, bad = 0;

  mem_access #(.MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_memRead(mem_read), .i_memWrite(mem_write),
    .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_bus_req(req), .o_bus_we(we), .o_bus_addr(bus_addr), .o_bus_be(be), .o_bus_wdata(bus_wdata),
    .i_bus_ack(ack), .i_bus_rdata(rdata_in), .o_stall(stall), .o_rdata(rdata),
    .o_rdata_valid(valid), .o_misalign(mis), .o_bus_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic r, input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    start = 1; mem_read = r; mem_write = w; size = s; uns = u; addr = a; wdata = d;
    #1;
  endtask

  task automatic idle_in;
    start = 0; mem_read = 0; mem_write = 0; ack = 0;
    #1;
  endtask

  task automatic test_reset;
    #12;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    total++; if ({valid, mis, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {valid, mis, err}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (be !== 4'h0) begin bad++; $display("FAIL reset_be got=%b exp=0000", be); end
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_lw;
    setop(1, 0, 2'b10, 0, 32'h100, 0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_c0 got=%0h exp=1", stall); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL lw_req_c0 got=%0h exp=0", req); end
    tick;
    ack = 1; rdata_in = 32'hDEADBEEF;
    total++; if (req !== 1'b1) begin bad++; $display("FAIL lw_req_c1 got=%0h exp=1", req); end
    total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", bus_addr); end
    total++; if (be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", be); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL lw_we got=%0h exp=0", we); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_c1 got=%0h exp=1", stall); end
    tick;
    ack = 0;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL lw_req_c2 got=%0h exp=0", req); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0h exp=1", valid); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall_c2 got=%0h exp=0", stall); end
    idle_in;
    tick;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lw_valid_after got=%0h exp=0", valid); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata_hold got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_sub_load(input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] rd,
                               input logic [3:0] be_exp, input logic [31:0] exp);
    setop(1, 0, s, u, a, 0);
    tick;
    ack = 1; rdata_in = rd;
    total++; if (be !== be_exp) begin bad++; $display("FAIL sub_be a=%h u=%0d got=%b exp=%b", a, u, be, be_exp); end
    tick;
    ack = 0;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL sub_valid a=%h u=%0d got=%0h exp=1", a, u, valid); end
    total++; if (rdata !== exp) begin bad++; $display("FAIL sub_rdata a=%h u=%0d got=%h exp=%h", a, u, rdata, exp); end
    idle_in;
    tick;
  endtask

  task automatic test_sh_wait;
    setop(1, 1, 2'b01, 0, 32'h202, 32'h0000ABCD);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ack = 1;
      total++; if (req !== 1'b1) begin bad++; $display("FAIL sh_req c%0d got=%0h exp=1", i + 1, req); end
      total++; if (we !== 1'b1) begin bad++; $display("FAIL sh_we c%0d got=%0h exp=1", i + 1, we); end
      total++; if (be !== 4'b1100) begin bad++; $display("FAIL sh_be c%0d got=%b exp=1100", i + 1, be); end
      total++; if (bus_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata c%0d got=%h exp=abcdabcd", i + 1, bus_wdata); end
      total++; if (bus_addr !== 32'h200) begin bad++; $display("FAIL sh_addr c%0d got=%h exp=00000200", i + 1, bus_addr); end
      tick;
    end
    ack = 0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sh_done_stall got=%0h exp=0", stall); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL sh_done_req got=%0h exp=0", req); end
    total++; if ({valid, mis, err} !== 3'b000) begin bad++; $display("FAIL sh_done_flags got=%b exp=000", {valid, mis, err}); end
    idle_in;
    tick;
  endtask

  task automatic test_misalign;
    setop(1, 0, 2'b10, 0, 32'h101, 0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall_c0 got=%0h exp=1", stall); end
    tick;
    total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h exp=1", mis); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis_stall_c1 got=%0h exp=0", stall); end
    total++; if ({req, valid, err} !== 3'b000) begin bad++; $display("FAIL mis_others got=%b exp=000", {req, valid, err}); end
    idle_in;
    tick;
    total++; if (mis !== 1'b0) begin bad++; $display("FAIL mis_after got=%0h exp=0", mis); end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    setop(0, 1, 2'b10, 0, 32'h300, 32'h11223344);
    tick;
    for (int i = 0; i < 40 && req; i++) begin
      n++;
      tick;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", err); end
    total++; if ({stall, valid, mis} !== 3'b000) begin bad++; $display("FAIL to_done_others got=%b exp=000", {stall, valid, mis}); end
    idle_in;
    tick;
    total++; if ({err, req, stall} !== 3'b000) begin bad++; $display("FAIL to_idle got=%b exp=000", {err, req, stall}); end
  endtask

  task automatic test_ack_at_limit;
    setop(1, 0, 2'b10, 0, 32'h400, 0);
    tick;
    repeat (15) tick;
    total++; if (req !== 1'b1) begin bad++; $display("FAIL lim_req got=%0h exp=1", req); end
    ack = 1; rdata_in = 32'h12345678;
    tick;
    ack = 0;
    total++; if ({valid, err} !== 2'b10) begin bad++; $display("FAIL lim_flags got=%b exp=10", {valid, err}); end
    total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL lim_rdata got=%h exp=12345678", rdata); end
    idle_in;
    tick;
  endtask

  task automatic test_reset_midflight;
    setop(1, 0, 2'b10, 0, 32'h500, 0);
    tick;
    tick;
    total++; if (req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%0h exp=1", req); end
    idle_in;
    rst_n = 0;
    #1;
    total++; if ({req, stall} !== 2'b00) begin bad++; $display("FAIL rst_drop got=%b exp=00", {req, stall}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    #2;
    rst_n = 1;
    setop(1, 0, 2'b10, 0, 32'h600, 0);
    tick;
    total++; if (req !== 1'b1 || bus_addr !== 32'h600) begin bad++; $display("FAIL rst_new_req got=%0h/%h exp=1/00000600", req, bus_addr); end
    ack = 1; rdata_in = 32'hCAFEF00D;
    tick;
    ack = 0;
    total++; if (valid !== 1'b1 || rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_new_load got=%0h/%h exp=1/cafef00d", valid, rdata); end
    idle_in;
    tick;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sub_load(2'b00, 0, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
    test_sub_load(2'b00, 1, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
    test_sub_load(2'b01, 0, 32'h102, 32'h87650000, 4'b1100, 32'hFFFF8765);
    test_sub_load(2'b01, 1, 32'h102, 32'h87650000, 4'b1100, 32'h00008765);
    test_sh_wait;
    test_misalign;
    test_timeout;
    test_ack_at_limit;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
